// File: rtl/rtype_control_sequencer.sv
// Control-step FSM for the bus datapath: fetch, decode, register-to-register ALU
// and mul/div sequencing with one-hot register enables and unit strobes.
module rtype_control_sequencer #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OPCODE_W  = 5,
  parameter int ALU_SEL_W = 4,
  parameter int IR_W      = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 run,
  input  logic                 mem_ready,
  input  logic [IR_W-1:0]      ir,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 Zin,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 PCin,
  output logic                 MDRin,
  output logic                 Read,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 HIin,
  output logic                 LOin,
  output logic [NUM_REGS-1:0]  r_in,
  output logic [NUM_REGS-1:0]  r_out,
  output logic [ALU_SEL_W-1:0] ALU_select,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  localparam int RA_HI = IR_W - 1 - OPCODE_W;
  localparam int RB_HI = RA_HI - REG_IDX_W;
  localparam int RC_HI = RB_HI - REG_IDX_W;
  localparam int LO_HI = RC_HI - REG_IDX_W;
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  state_t state_q, state_d;
  logic [REG_IDX_W-1:0] ra_q, ra_d, rc_q, rc_d;
  logic [ALU_SEL_W-1:0] alu_q, alu_d;
  logic                 md_q, md_d;

  logic [OPCODE_W-1:0]  opc;
  logic [REG_IDX_W-1:0] ra, rb, rc;
  logic                 op_ok, regs_ok, legal, is_md;
  logic [ALU_SEL_W-1:0] alu_code;
  logic                 unused_ir;

  assign opc = ir[IR_W-1 -: OPCODE_W];
  assign ra  = ir[RA_HI -: REG_IDX_W];
  assign rb  = ir[RB_HI -: REG_IDX_W];
  assign rc  = ir[RC_HI -: REG_IDX_W];
  assign unused_ir = ^ir[LO_HI:0];

  assign op_ok   = (opc != '0) && (opc <= OPCODE_W'(15));
  assign regs_ok = (int'(ra) < NUM_REGS) && (int'(rb) < NUM_REGS)
                && (int'(rc) < NUM_REGS);
  assign legal   = op_ok && regs_ok;
  assign is_md   = opc >= OPCODE_W'(14);
  // mul/div codes (1101, 1110) fall out of the same opcode-1 mapping
  assign alu_code = ALU_SEL_W'(opc - OPCODE_W'(1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rc_q    <= '0;
      alu_q   <= '0;
      md_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rc_q    <= rc_d;
      alu_q   <= alu_d;
      md_q    <= md_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ra_d       = ra_q;
    rc_d       = rc_q;
    alu_d      = alu_q;
    md_d       = md_q;
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    Read       = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    r_in       = '0;
    r_out      = '0;
    ALU_select = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (legal) begin
          r_out   = ONE << rb;
          Yin     = 1'b1;
          ra_d    = ra;
          rc_d    = rc;
          alu_d   = alu_code;
          md_d    = is_md;
          state_d = S_T4;
        end else begin
          illegal = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_T4: begin
        r_out      = ONE << rc_q;
        ALU_select = alu_q;
        Zin        = 1'b1;
        state_d    = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (md_q) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          r_in    = ONE << ra_q;
          done    = 1'b1;
          state_d = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
        state_d  = run ? S_T0 : S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule
